// File: rtl/seq_match_ctrl.sv
// Job controller for bit-serial pattern detection: takes a configured job,
// consumes cfg_len stream bits over valid/ready and counts pattern matches.
module seq_match_ctrl #(
  parameter int PAT_W = 6,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   window;
  logic [PAT_W-1:0]   pat;
  logic               ovl;
  logic [FILL_W-1:0]  fill;
  logic [LEN_W-1:0]   bits_left;

  logic               cfg_fire;
  logic               take;
  logic               hit_p0;
  logic [PAT_W-1:0]   win_nxt;
  logic [FILL_W-1:0]  fill_nxt;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] v);
    return (v == FULL) ? v : v + FILL_W'(1);
  endfunction

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign in_ready  = (state == RUN) && !abort;
  assign done      = (state == DONE);

  always_comb begin
    cfg_fire  = cfg_valid && (state == IDLE);
    take      = in_valid && in_ready;
    win_nxt   = {window[PAT_W-2:0], in_bit};
    fill_nxt  = sat_fill(fill);
    hit_p0    = take && (win_nxt == pat) && (fill_nxt == FULL);
    state_nxt = state;
    case (state)
      IDLE: if (cfg_fire) state_nxt = (cfg_len != '0) ? RUN : DONE;
      RUN: begin
        if (abort)                                 state_nxt = IDLE;
        else if (take && bits_left == LEN_W'(1))   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: accepted bit -> registered match pulse and count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      window    <= '0;
      fill      <= '0;
      bits_left <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      state <= state_nxt;
      match <= hit_p0;
      if (cfg_fire) begin
        window    <= '0;
        fill      <= '0;
        bits_left <= cfg_len;
        match_cnt <= '0;
      end else if (take) begin
        window    <= win_nxt;
        fill      <= (hit_p0 && !ovl) ? '0 : fill_nxt;
        bits_left <= bits_left - LEN_W'(1);
        if (hit_p0) match_cnt <= sat_cnt(match_cnt);
      end
    end
  end

  // Job configuration is plain data, only meaningful after a cfg accept
  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      pat <= cfg_pattern;
      ovl <= cfg_overlap;
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl; a second instance with CNT_W=2 shares the
// stimulus to exercise counter saturation.
module tb_seq_match_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [5:0] cfg_pattern = '0;
  logic [7:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;

  logic       cfg_ready, in_ready, busy, match, done;
  logic [7:0] match_cnt;
  logic       s_cfg_ready, s_in_ready, s_busy, s_match, s_done;
  logic [1:0] s_match_cnt;

  int nchk = 0, nbad = 0;
  int n_match = 0, n_done = 0, n_acc = 0, n_busy = 0, n_coinc = 0, n_ready = 0;
  int b_match, b_done, b_acc, b_busy, b_coinc, b_ready;

  always #5 clk = ~clk;

  seq_match_ctrl dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .busy(busy), .match(match), .match_cnt(match_cnt), .done(done)
  );

  seq_match_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .abort(abort), .in_valid(in_valid), .in_ready(s_in_ready), .in_bit(in_bit),
    .busy(s_busy), .match(s_match), .match_cnt(s_match_cnt), .done(s_done)
  );

  always @(negedge clk) begin
    if (reset) begin
      if (match)             n_match++;
      if (done)              n_done++;
      if (in_valid && in_ready) n_acc++;
      if (busy)              n_busy++;
      if (match && done)     n_coinc++;
      if (in_ready)          n_ready++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nbad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_match = n_match; b_done = n_done; b_acc = n_acc;
    b_busy = n_busy; b_coinc = n_coinc; b_ready = n_ready;
  endtask

  task automatic start(input logic [5:0] p, input logic [7:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  // Bits are sent MSB first; gap inserts an idle cycle between bits.
  task automatic feed(input logic [15:0] bits, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        cyc();
      end
      in_valid = 1'b1;
      in_bit   = bits[n-1-i];
      cyc();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_done", done, 0);
    @(negedge clk) reset = 1'b1;
    cyc();

    // Test 1: single non-overlapping match on the last bit
    mark();
    start(6'b110011, 8'd6, 1'b0);
    feed(16'b110011, 6, 1'b0);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_match", match, 1);
    chk("t1_cnt", match_cnt, 1);
    cyc();
    @(negedge clk);
    chk("t1_idle", cfg_ready, 1);
    chk("t1_done_off", done, 0);
    chk("t1_nmatch", n_match - b_match, 1);
    chk("t1_coinc", n_coinc - b_coinc, 1);
    chk("t1_nacc", n_acc - b_acc, 6);
    cyc();

    // Test 2: overlap on/off over 1100110011
    mark();
    start(6'b110011, 8'd10, 1'b1);
    feed(16'b1100110011, 10, 1'b0);
    @(negedge clk);
    chk("t2o_cnt", match_cnt, 2);
    chk("t2o_done", done, 1);
    cyc();
    chk("t2o_nmatch", n_match - b_match, 2);
    mark();
    start(6'b110011, 8'd10, 1'b0);
    feed(16'b1100110011, 10, 1'b0);
    @(negedge clk);
    chk("t2n_cnt", match_cnt, 1);
    chk("t2n_match_end", match, 0);
    cyc();
    chk("t2n_nmatch", n_match - b_match, 1);

    // Test 3: zero-length job
    mark();
    start(6'b101010, 8'd0, 1'b0);
    @(negedge clk);
    chk("t3_done", done, 1);
    chk("t3_cnt", match_cnt, 0);
    chk("t3_in_ready", in_ready, 0);
    cyc();
    @(negedge clk);
    chk("t3_nready", n_ready - b_ready, 0);
    chk("t3_ndone", n_done - b_done, 1);
    cyc();

    // Test 4: in_valid toggling every cycle
    mark();
    start(6'b110011, 8'd8, 1'b0);
    feed(16'b00110011, 8, 1'b1);
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_cnt", match_cnt, 1);
    cyc();
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t4_nacc", n_acc - b_acc, 8);
    chk("t4_nbusy", n_busy - b_busy, 15);
    chk("t4_ndone", n_done - b_done, 1);

    // Test 5: abort after 3 bits, then abort with a retained count
    mark();
    start(6'b110011, 8'd10, 1'b0);
    feed(16'b110, 3, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
    @(negedge clk);
    chk("t5_in_ready_abort", in_ready, 0);
    cyc();
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_idle", cfg_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_nacc", n_acc - b_acc, 3);
    chk("t5_ndone", n_done - b_done, 0);
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5_abort_idle", cfg_ready, 1);
    start(6'b110011, 8'd10, 1'b0);
    feed(16'b1100110, 7, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    @(negedge clk);
    chk("t5_cnt_kept", match_cnt, 1);
    chk("t5_ndone2", n_done - b_done, 0);
    start(6'b110011, 8'd0, 1'b0);
    @(negedge clk);
    chk("t5_cnt_clr", match_cnt, 0);
    cyc();

    // Test 6: async reset mid-job, then counter saturation
    mark();
    start(6'b000000, 8'd10, 1'b1);
    feed(16'b0, 7, 1'b0);
    @(negedge clk);
    chk("t6_cnt_pre", match_cnt, 2);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_cnt", match_cnt, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cfg_ready", cfg_ready, 1);
    cyc();
    reset = 1'b1;
    cyc();
    chk("t6_ndone", n_done - b_done, 0);
    start(6'b000000, 8'd10, 1'b1);
    feed(16'b0, 10, 1'b0);
    @(negedge clk);
    chk("t6_cnt5", match_cnt, 5);
    chk("t6_sat_cnt", s_match_cnt, 3);
    chk("t6_sat_done", s_done, 1);
    cyc();

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
